// File: rtl/hexa_pkg.sv
// ============================================================================
//  Module   : hexa_pkg
//  Purpose  : Shared types and constants for the hexa router and its PE injector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hexa_pkg;

   // Router port indices
   localparam int c_PORT_XPOS = 0;
   localparam int c_PORT_XNEG = 1;
   localparam int c_PORT_YPOS = 2;
   localparam int c_PORT_YNEG = 3;
   localparam int c_PORT_PE   = 4;

   // Header flit layout
   localparam int c_HDR_W      = 32;
   localparam int c_COORD_W    = 4;
   localparam int c_LEN_W      = 3;
   localparam int c_HDR_DX_LSB = 28;
   localparam int c_HDR_DY_LSB = 24;
   localparam int c_HDR_SX_LSB = 20;
   localparam int c_HDR_SY_LSB = 16;
   localparam int c_HDR_LEN_LSB = 13;

   // Differential strobe encodings, {p, n}
   localparam logic [1:0] c_DP_VALID = 2'b10;
   localparam logic [1:0] c_DP_IDLE  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } inj_state_t;

   function automatic logic [c_HDR_W-1:0] build_header(
      input logic [c_COORD_W-1:0] dx,
      input logic [c_COORD_W-1:0] dy,
      input logic [c_COORD_W-1:0] sx,
      input logic [c_COORD_W-1:0] sy,
      input logic [c_LEN_W-1:0]   len
   );
      logic [c_HDR_W-1:0] h;
      h = '0;
      h[c_HDR_DX_LSB  +: c_COORD_W] = dx;
      h[c_HDR_DY_LSB  +: c_COORD_W] = dy;
      h[c_HDR_SX_LSB  +: c_COORD_W] = sx;
      h[c_HDR_SY_LSB  +: c_COORD_W] = sy;
      h[c_HDR_LEN_LSB +: c_LEN_W]   = len;
      return h;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hexa_pe_injector_if.sv
// ============================================================================
//  Module   : hexa_pe_injector_if
//  Purpose  : PE descriptor/payload handshakes plus the router input channel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hexa_pe_injector_if
   import hexa_pkg::*;
#(
   parameter int CHANNEL_WIDTH = 32
);
   logic                     pe_valid;
   logic                     pe_ready;
   logic [c_COORD_W-1:0]     pe_dest_x;
   logic [c_COORD_W-1:0]     pe_dest_y;
   logic [c_LEN_W-1:0]       pe_len;
   logic [CHANNEL_WIDTH-1:0] pe_data;
   logic                     pe_data_valid;
   logic                     pe_data_ready;
   logic                     credit_in;
   logic [CHANNEL_WIDTH-1:0] channel_out;
   logic                     diff_pair_p;
   logic                     diff_pair_n;
   logic                     busy;
   logic                     credit_err;

   // Injector side
   modport slave (
      input  pe_valid, pe_dest_x, pe_dest_y, pe_len,
      input  pe_data, pe_data_valid, credit_in,
      output pe_ready, pe_data_ready, channel_out,
      output diff_pair_p, diff_pair_n, busy, credit_err
   );

   // PE / router side
   modport master (
      output pe_valid, pe_dest_x, pe_dest_y, pe_len,
      output pe_data, pe_data_valid, credit_in,
      input  pe_ready, pe_data_ready, channel_out,
      input  diff_pair_p, diff_pair_n, busy, credit_err
   );

endinterface

`default_nettype wire

// File: rtl/hexa_credit_counter.sv
// ============================================================================
//  Module   : hexa_credit_counter
//  Purpose  : Credit tracker for one router output; saturates with sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hexa_credit_counter #(
   parameter int DEPTH = 4
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic                         consume,
   input  wire logic                         credit_in,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic                              has_credit,
   output logic                              overflow
);

   localparam int                c_CW   = $clog2(DEPTH + 1);
   localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);
   localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

   logic [c_CW-1:0] r_count;
   logic            r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= c_FULL;
         r_overflow <= 1'b0;
      end else begin
         // A spend and a return in the same cycle cancel out
         case ({consume, credit_in})
            2'b10:   r_count <= r_count - c_ONE;
            2'b01: begin
               if (r_count == c_FULL) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_count <= r_count + c_ONE;
               end
            end
            default: r_count <= r_count;
         endcase
      end
   end

   assign count      = r_count;
   assign has_credit = (r_count != '0);
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: rtl/hexa_pe_injector.sv
// ============================================================================
//  Module   : hexa_pe_injector
//  Purpose  : Builds header + payload flits from PE descriptors for router port 4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hexa_pe_injector
   import hexa_pkg::*;
#(
   parameter int XCOR          = 2,
   parameter int YCOR          = 2,
   parameter int CHANNEL_WIDTH = 32,
   parameter int BUFFER_DEPTH  = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   hexa_pe_injector_if.slave bus
);

   localparam int c_CW = $clog2(BUFFER_DEPTH + 1);
   localparam logic [c_COORD_W-1:0] c_SX = c_COORD_W'(XCOR);
   localparam logic [c_COORD_W-1:0] c_SY = c_COORD_W'(YCOR);
   localparam logic [c_LEN_W-1:0]   c_LEN_ONE = c_LEN_W'(1);

   inj_state_t r_state;
   inj_state_t w_state_nxt;

   logic [c_COORD_W-1:0]     r_dest_x;
   logic [c_COORD_W-1:0]     r_dest_y;
   logic [c_LEN_W-1:0]       r_len;
   logic [c_LEN_W-1:0]       r_remaining;
   logic [CHANNEL_WIDTH-1:0] r_channel;
   logic [1:0]               r_dp;

   logic [c_CW-1:0]          w_count;
   logic                     w_has_credit;
   logic                     w_overflow;
   logic                     w_desc_hs;
   logic                     w_emit_hdr;
   logic                     w_emit_pay;
   logic                     w_consume;
   logic [CHANNEL_WIDTH-1:0] w_header;

   hexa_credit_counter #(
      .DEPTH (BUFFER_DEPTH)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .consume    (w_consume),
      .credit_in  (bus.credit_in),
      .count      (w_count),
      .has_credit (w_has_credit),
      .overflow   (w_overflow)
   );

   assign w_header  = CHANNEL_WIDTH'(build_header(r_dest_x, r_dest_y, c_SX, c_SY, r_len));
   assign w_consume = w_emit_hdr | w_emit_pay;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ready outputs depend only on state and credit, never on the valids
   always_comb begin
      w_state_nxt       = r_state;
      bus.pe_ready      = 1'b0;
      bus.pe_data_ready = 1'b0;
      w_desc_hs         = 1'b0;
      w_emit_hdr        = 1'b0;
      w_emit_pay        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.pe_ready = 1'b1;
            if (bus.pe_valid) begin
               w_desc_hs   = 1'b1;
               w_state_nxt = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (w_has_credit) begin
               w_emit_hdr  = 1'b1;
               w_state_nxt = (r_len != '0) ? ST_PAYLOAD : ST_IDLE;
            end
         end
         ST_PAYLOAD: begin
            bus.pe_data_ready = w_has_credit;
            if (bus.pe_data_valid && w_has_credit) begin
               w_emit_pay = 1'b1;
               if (r_remaining == c_LEN_ONE) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dest_x    <= '0;
         r_dest_y    <= '0;
         r_len       <= '0;
         r_remaining <= '0;
      end else begin
         if (w_desc_hs) begin
            r_dest_x    <= bus.pe_dest_x;
            r_dest_y    <= bus.pe_dest_y;
            r_len       <= bus.pe_len;
            r_remaining <= bus.pe_len;
         end else if (w_emit_pay) begin
            r_remaining <= r_remaining - c_LEN_ONE;
         end
      end
   end

   // Flits are registered: visible for exactly the cycle after emission
   always_ff @(posedge clk) begin
      if (rst) begin
         r_channel <= '0;
         r_dp      <= c_DP_IDLE;
      end else begin
         if (w_emit_hdr) begin
            r_channel <= w_header;
            r_dp      <= c_DP_VALID;
         end else if (w_emit_pay) begin
            r_channel <= bus.pe_data;
            r_dp      <= c_DP_VALID;
         end else begin
            r_dp      <= c_DP_IDLE;
         end
         if (w_consume) begin
            assert (w_count != '0);
         end
      end
   end

   assign bus.channel_out = r_channel;
   assign bus.diff_pair_p = r_dp[1];
   assign bus.diff_pair_n = r_dp[0];
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.credit_err  = w_overflow;

endmodule

`default_nettype wire

// File: tb/tb_hexa_pe_injector.sv
// ============================================================================
//  Module   : tb_hexa_pe_injector
//  Purpose  : Scoreboard bench for hexa_pe_injector with directed packets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hexa_pe_injector;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hexa_pe_injector_if #(.CHANNEL_WIDTH(32)) bus ();

   hexa_pe_injector #(
      .XCOR          (2),
      .YCOR          (2),
      .CHANNEL_WIDTH (32),
      .BUFFER_DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          tests   = 0;
   int          errors  = 0;
   int          n_flits = 0;
   int          snap;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      exp_q.delete();
   endtask

   task automatic send_desc(input logic [3:0] x, input logic [3:0] y,
                            input logic [2:0] len, input logic [31:0] exp_hdr);
      int t;
      bus.pe_dest_x = x;
      bus.pe_dest_y = y;
      bus.pe_len    = len;
      bus.pe_valid  = 1'b1;
      exp_q.push_back(exp_hdr);
      t = 0;
      while (!bus.pe_ready && t < 50) begin
         tick();
         t++;
      end
      if (t == 50) begin
         tests++;
         errors++;
         $display("FAIL desc_timeout: got no pe_ready, expected it within 50 cycles");
      end else begin
         tick();
      end
      bus.pe_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] data);
      int t;
      bus.pe_data       = data;
      bus.pe_data_valid = 1'b1;
      exp_q.push_back(data);
      t = 0;
      while (!bus.pe_data_ready && t < 50) begin
         tick();
         t++;
      end
      if (t == 50) begin
         tests++;
         errors++;
         $display("FAIL word_timeout: got no pe_data_ready, expected it within 50 cycles");
      end else begin
         tick();
      end
      bus.pe_data_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_flit;
      bus.pe_valid      = 1'b0;
      bus.pe_dest_x     = '0;
      bus.pe_dest_y     = '0;
      bus.pe_len        = '0;
      bus.pe_data       = '0;
      bus.pe_data_valid = 1'b0;
      bus.credit_in     = 1'b0;

      // Monitor: pops the scoreboard whenever the strobe marks a flit
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               check("strobe_legal", 32'(bus.diff_pair_p ^ bus.diff_pair_n), 32'd1);
               if (bus.diff_pair_p) begin
                  n_flits++;
                  if (exp_q.size() == 0) begin
                     tests++;
                     errors++;
                     $display("FAIL flit_unexpected: got 0x%08h, expected no flit", bus.channel_out);
                  end else begin
                     exp_flit = exp_q.pop_front();
                     check("flit", bus.channel_out, exp_flit);
                  end
               end
            end
         end
      join_none

      // Reset values
      tick();
      tick();
      check("rst_pe_ready",      32'(bus.pe_ready),      32'd1);
      check("rst_pe_data_ready", 32'(bus.pe_data_ready), 32'd0);
      check("rst_busy",          32'(bus.busy),          32'd0);
      check("rst_credit_err",    32'(bus.credit_err),    32'd0);
      check("rst_channel",       bus.channel_out,        32'd0);
      check("rst_dp",            32'({bus.diff_pair_p, bus.diff_pair_n}), 32'b01);
      check("rst_credits",       32'(dut.u_credit.count), 32'd4);
      rst = 1'b0;
      tick();

      // Basic packet, credits full
      send_desc(4'd1, 4'd3, 3'd2, 32'h1322_4000);
      send_word(32'hA5A5_0001);
      send_word(32'hA5A5_0002);
      check("t1_last_strobe", 32'({bus.diff_pair_p, bus.diff_pair_n}), 32'b10);
      tick();
      check("t1_idle_strobe", 32'({bus.diff_pair_p, bus.diff_pair_n}), 32'b01);
      check("t1_busy", 32'(bus.busy), 32'd0);

      // Header-only packet
      do_reset();
      rst = 1'b0;
      send_desc(4'd2, 4'd2, 3'd0, 32'h2222_0000);
      check("t2_busy_hi", 32'(bus.busy), 32'd1);
      tick();
      check("t2_busy_lo", 32'(bus.busy), 32'd0);
      check("t2_hdr_strobe", 32'(bus.diff_pair_p), 32'd1);
      tick();
      check("t2_idle_strobe", 32'(bus.diff_pair_p), 32'd0);

      // Credit starvation: four flits, then one flit per credit
      do_reset();
      rst = 1'b0;
      tick();
      snap = n_flits;
      send_desc(4'd0, 4'd1, 3'd7, 32'h0122_E000);
      send_word(32'hB000_0001);
      send_word(32'hB000_0002);
      send_word(32'hB000_0003);
      bus.pe_data       = 32'hB000_0004;
      bus.pe_data_valid = 1'b1;
      exp_q.push_back(32'hB000_0004);
      tick();
      tick();
      tick();
      check("t3_stall_ready", 32'(bus.pe_data_ready), 32'd0);
      check("t3_four_flits",  32'(n_flits - snap),    32'd4);
      for (int i = 4; i <= 7; i++) begin
         bus.credit_in = 1'b1;
         tick();
         bus.credit_in = 1'b0;
         check("t3_credit_ready", 32'(bus.pe_data_ready), 32'd1);
         snap = n_flits;
         tick();
         if (i < 7) begin
            bus.pe_data = 32'hB000_0000 | 32'(i + 1);
            exp_q.push_back(32'hB000_0000 | 32'(i + 1));
         end else begin
            bus.pe_data_valid = 1'b0;
         end
         tick();
         check("t3_one_flit", 32'(n_flits - snap), 32'd1);
         if (i < 7) begin
            check("t3_restall", 32'(bus.pe_data_ready), 32'd0);
         end else begin
            check("t3_done_idle", 32'(bus.pe_ready), 32'd1);
         end
      end

      // Credit return coinciding with a spend at one credit
      do_reset();
      rst = 1'b0;
      send_desc(4'd3, 4'd0, 3'd4, 32'h3022_8000);
      send_word(32'hC000_0001);
      send_word(32'hC000_0002);
      check("t4_count_before", 32'(dut.u_credit.count), 32'd1);
      bus.pe_data       = 32'hC000_0003;
      bus.pe_data_valid = 1'b1;
      bus.credit_in     = 1'b1;
      exp_q.push_back(32'hC000_0003);
      tick();
      bus.credit_in     = 1'b0;
      bus.pe_data_valid = 1'b0;
      check("t4_count_same", 32'(dut.u_credit.count), 32'd1);
      check("t4_no_stall",   32'(bus.pe_data_ready),  32'd1);
      send_word(32'hC000_0004);
      check("t4_count_zero", 32'(dut.u_credit.count), 32'd0);
      check("t4_idle",       32'(bus.pe_ready),       32'd1);

      // Credit overflow
      do_reset();
      rst = 1'b0;
      check("t5_err_clear", 32'(bus.credit_err), 32'd0);
      bus.credit_in = 1'b1;
      tick();
      bus.credit_in = 1'b0;
      check("t5_err_set",   32'(bus.credit_err),      32'd1);
      check("t5_count_sat", 32'(dut.u_credit.count),  32'd4);
      tick();
      tick();
      tick();
      check("t5_err_sticky", 32'(bus.credit_err), 32'd1);

      // Reset in the middle of a payload
      do_reset();
      rst = 1'b0;
      check("t6_err_cleared", 32'(bus.credit_err), 32'd0);
      send_desc(4'd1, 4'd1, 3'd5, 32'h1122_A000);
      send_word(32'hD000_0001);
      send_word(32'hD000_0002);
      do_reset();
      check("t6_pe_ready", 32'(bus.pe_ready), 32'd1);
      check("t6_dp",       32'({bus.diff_pair_p, bus.diff_pair_n}), 32'b01);
      check("t6_busy",     32'(bus.busy), 32'd0);
      check("t6_credits",  32'(dut.u_credit.count), 32'd4);
      rst = 1'b0;
      send_desc(4'd2, 4'd3, 3'd1, 32'h2322_2000);
      send_word(32'hE000_0001);
      tick();
      tick();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

`default_nettype wire
